// File: rtl/adc_stream_fifo_pkg.sv
// Shared constants and pointer arithmetic for the AD9226 -> W5500 sample FIFO.
package adc_stream_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH         = 48;
    localparam int DEFAULT_ADDRESS_WIDTH      = 8;
    localparam int DEFAULT_ALMOST_FULL_LEVEL  = 224;
    localparam int DEFAULT_ALMOST_EMPTY_LEVEL = 16;

    // Pointers carry one extra MSB, so the difference modulo 2*DEPTH spans 0..DEPTH.
    function automatic logic [31:0] ptr_fill(input logic [31:0] wr_ptr,
                                             input logic [31:0] rd_ptr,
                                             input int          address_width);
        logic [31:0] mask;
        mask = (32'd1 << (address_width + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/adc_stream_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable (M10K style).
module adc_stream_fifo_sdp_ram #(
    parameter int DATA_WIDTH    = 48,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Same-address read and write return the old word, which the full-FIFO stream relies on.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        if (read_enable) begin
            read_data <= mem[read_address];
        end
    end

endmodule

// File: rtl/adc_stream_fifo.sv
// Sample FIFO with fill level, thresholds, sticky error flags and flush.
// Define ADC_STREAM_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module adc_stream_fifo
    import adc_stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH      = DEFAULT_ADDRESS_WIDTH,
    parameter int ALMOST_FULL_LEVEL  = DEFAULT_ALMOST_FULL_LEVEL,
    parameter int ALMOST_EMPTY_LEVEL = DEFAULT_ALMOST_EMPTY_LEVEL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   write_enabled,
    input  logic                   read_enabled,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_out_valid,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [ADDRESS_WIDTH:0] fill_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int PW    = ADDRESS_WIDTH + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_P    = ptr_t'(ALMOST_FULL_LEVEL);
    localparam ptr_t AE_P    = ptr_t'(ALMOST_EMPTY_LEVEL);

    if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL >= ALMOST_FULL_LEVEL) begin : g_bad_thresholds
        $error("adc_stream_fifo: need ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
    end

    ptr_t                     wr_ptr;
    ptr_t                     rd_ptr;
    ptr_t                     wr_ptr_next;
    ptr_t                     rd_ptr_next;
    ptr_t                     fill_next;
    logic                     rd_acc;
    logic                     wr_acc;
    logic                     ram_rd_en;
    logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0]    ram_q;

    // rd_ptr tracks consumed words, so fill_level includes anything held in the output stage.
    assign wr_acc      = write_enabled && (!fifo_full || rd_acc);
    assign wr_ptr_next = wr_ptr + ptr_t'(wr_acc);
    assign rd_ptr_next = rd_ptr + ptr_t'(rd_acc);
    assign fill_next   = ptr_t'(ptr_fill(32'(wr_ptr_next), 32'(rd_ptr_next), ADDRESS_WIDTH));

    adc_stream_fifo_sdp_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_sdp_ram (
        .clk           (clk),
        .write_enable  (wr_acc && !flush),
        .write_address (wr_ptr[ADDRESS_WIDTH-1:0]),
        .write_data    (data_in),
        .read_enable   (ram_rd_en),
        .read_address  (ram_rd_addr),
        .read_data     (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            fill_level   <= fill_next;
            fifo_empty   <= (fill_next == '0);
            fifo_full    <= (fill_next == DEPTH_P);
            almost_empty <= (fill_next <= AE_P);
            almost_full  <= (fill_next >= AF_P);
            if (write_enabled && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (read_enabled && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef ADC_STREAM_FIFO_FWFT_EN
    // Two-stage prefetch: the RAM read register acts as a skid stage behind data_out.
    ptr_t fetch_ptr;
    logic q_valid;
    logic out_take;
    logic fetch;

    assign rd_acc      = read_enabled && data_out_valid;
    assign out_take    = q_valid && (!data_out_valid || rd_acc);
    assign fetch       = (fetch_ptr != wr_ptr) && (!q_valid || out_take);
    assign ram_rd_en   = fetch && !flush;
    assign ram_rd_addr = fetch_ptr[ADDRESS_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_ptr      <= '0;
            q_valid        <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else if (flush) begin
            fetch_ptr      <= '0;
            q_valid        <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            if (fetch) begin
                fetch_ptr <= fetch_ptr + ptr_t'(1);
            end
            q_valid <= fetch || (q_valid && !out_take);
            if (out_take) begin
                data_out       <= ram_q;
                data_out_valid <= 1'b1;
            end else if (rd_acc) begin
                data_out_valid <= 1'b0;
            end
        end
    end
`else
    // The RAM read register is data_out; has_data masks it to zero until the first read.
    logic has_data;

    assign rd_acc      = read_enabled && !fifo_empty;
    assign ram_rd_en   = rd_acc && !flush;
    assign ram_rd_addr = rd_ptr[ADDRESS_WIDTH-1:0];
    assign data_out    = has_data ? ram_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_valid <= 1'b0;
            has_data       <= 1'b0;
        end else if (flush) begin
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= rd_acc;
            if (rd_acc) begin
                has_data <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_stream_fifo.sv
// Self-checking bench for adc_stream_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_adc_stream_fifo;

    localparam int DW    = 48;
    localparam int DEPTH = 256;
    localparam int AF    = 224;
    localparam int AE    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [DW-1:0] data_in;
    logic          write_enabled;
    logic          read_enabled;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic [8:0]    fill_level;
    logic          overflow;
    logic          underflow;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic          m_dov;
    logic [DW-1:0] m_dout;

    typedef struct {
        logic          f;
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            fill;
        logic          dov;
        logic [DW-1:0] dout;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t tbl[10];

    adc_stream_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .data_in        (data_in),
        .write_enabled  (write_enabled),
        .read_enabled   (read_enabled),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .almost_empty   (almost_empty),
        .almost_full    (almost_full),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
        flush         = f;
        write_enabled = w;
        read_enabled  = r;
        data_in       = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dov  = 1'b0;
        m_dout = '0;
    endtask

    // Behaviour of one clock edge in registered-read mode, from the acceptance rules.
    task automatic model_step(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
        logic rd_ok;
        logic wr_ok;
        if (f) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dov = 1'b0;
        end else begin
            rd_ok = r && (exp_q.size() > 0);
            wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = exp_q.pop_front();
            m_dov = rd_ok;
            if (wr_ok) exp_q.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        check({tag, " fill_level"},     64'(fill_level),     64'(n));
        check({tag, " fifo_empty"},     64'(fifo_empty),     64'(n == 0));
        check({tag, " fifo_full"},      64'(fifo_full),      64'(n == DEPTH));
        check({tag, " almost_empty"},   64'(almost_empty),   64'(n <= AE));
        check({tag, " almost_full"},    64'(almost_full),    64'(n >= AF));
        check({tag, " overflow"},       64'(overflow),       64'(m_ovf));
        check({tag, " underflow"},      64'(underflow),      64'(m_unf));
        check({tag, " data_out_valid"}, 64'(data_out_valid), 64'(m_dov));
        check({tag, " data_out"},       64'(data_out),       64'(m_dout));
    endtask

    task automatic drive(input string tag, input logic f, input logic w, input logic r,
                         input logic [DW-1:0] d);
        set_in(f, w, r, d);
        model_step(f, w, r, d);
        tick();
        check_model(tag);
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        #2;
        model_reset();
        check_model("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic run_std();
        logic [DW-1:0] d;
        int wb;
        int rb;

        // table vectors from a freshly reset FIFO
        tbl[0] = '{1'b0, 1'b0, 1'b1, 48'h0,   0, 1'b0, 48'h0,   1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 48'h111, 1, 1'b0, 48'h0,   1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 48'h222, 2, 1'b0, 48'h0,   1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 48'h333, 2, 1'b1, 48'h111, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 48'h0,   2, 1'b0, 48'h111, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 48'h999, 0, 1'b0, 48'h111, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 48'h444, 1, 1'b0, 48'h111, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 48'h0,   0, 1'b1, 48'h444, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 48'h555, 1, 1'b0, 48'h444, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 48'h0,   0, 1'b1, 48'h555, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].d);
            model_step(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].d);
            tick();
            check($sformatf("vec%0d fill", i),  64'(fill_level),     64'(tbl[i].fill));
            check($sformatf("vec%0d empty", i), 64'(fifo_empty),     64'(tbl[i].fill == 0));
            check($sformatf("vec%0d dov", i),   64'(data_out_valid), 64'(tbl[i].dov));
            check($sformatf("vec%0d dout", i),  64'(data_out),       64'(tbl[i].dout));
            check($sformatf("vec%0d ovf", i),   64'(overflow),       64'(tbl[i].ovf));
            check($sformatf("vec%0d unf", i),   64'(underflow),      64'(tbl[i].unf));
        end

        // fill to the brim, watching the almost_full threshold
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            drive("fill", 1'b0, 1'b1, 1'b0, 48'(i));
            if (i == AF - 1) check("af below threshold", 64'(almost_full), 64'd0);
            if (i == AF)     check("af at threshold",    64'(almost_full), 64'd1);
        end
        check("full after 256", 64'(fifo_full), 64'd1);
        check("fill after 256", 64'(fill_level), 64'd256);

        drive("overflow write", 1'b0, 1'b1, 1'b0, 48'hDEAD_BEEF_0000);
        check("overflow set", 64'(overflow), 64'd1);
        check("fill kept 256", 64'(fill_level), 64'd256);

        // full FIFO streaming across pointer wrap
        for (int i = 0; i < 300; i++) begin
            d = {16'($urandom), $urandom};
            drive("full stream", 1'b0, 1'b1, 1'b1, d);
        end

        for (int i = 0; i < DEPTH; i++) drive("drain", 1'b0, 1'b0, 1'b1, '0);

        for (int i = 0; i < 10; i++) drive("ten", 1'b0, 1'b1, 1'b0, 48'(i + 16'h700));
        check("ovf still set", 64'(overflow), 64'd1);
        drive("flush", 1'b1, 1'b0, 1'b0, '0);
        check("flush fill", 64'(fill_level), 64'd0);
        check("flush empty", 64'(fifo_empty), 64'd1);
        check("flush ovf", 64'(overflow), 64'd0);

        // randomized traffic with shifting biases and rare flushes
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                wb = $urandom_range(10, 95);
                rb = $urandom_range(10, 95);
            end
            d = {16'($urandom), $urandom};
            drive("random", ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < wb), ($urandom_range(0, 99) < rb), d);
        end

        // reset in the middle of traffic
        for (int i = 0; i < 5; i++) drive("pre reset", 1'b0, 1'b1, 1'b1, 48'(i + 100));
        reset = 1'b1;
        #2;
        model_reset();
        check_model("mid reset");
        @(negedge clk);
        reset = 1'b0;
        drive("post reset", 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic run_fwft();
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 48'h1234_5678_9ABC);
        tick();
        set_in(1'b0, 1'b0, 1'b0, '0);
        check("fwft N dov", 64'(data_out_valid), 64'd0);
        check("fwft N fill", 64'(fill_level), 64'd1);
        tick();
        check("fwft N+1 dov", 64'(data_out_valid), 64'd0);
        tick();
        check("fwft N+2 dov", 64'(data_out_valid), 64'd1);
        check("fwft N+2 dout", 64'(data_out), 64'h1234_5678_9ABC);
        set_in(1'b0, 1'b0, 1'b1, '0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, '0);
        check("fwft consume dov", 64'(data_out_valid), 64'd0);
        check("fwft consume fill", 64'(fill_level), 64'd0);
        check("fwft consume unf", 64'(underflow), 64'd0);
        set_in(1'b0, 1'b0, 1'b1, '0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, '0);
        check("fwft empty read unf", 64'(underflow), 64'd1);

        // full FIFO, overflow, then a gap-free drain
        for (int i = 1; i <= DEPTH; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 48'(i));
            tick();
        end
        check("fwft full", 64'(fifo_full), 64'd1);
        set_in(1'b0, 1'b1, 1'b0, 48'hDEAD_BEEF_0000);
        tick();
        check("fwft overflow", 64'(overflow), 64'd1);
        check("fwft fill 256", 64'(fill_level), 64'd256);
        set_in(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("fwft drain dov %0d", i), 64'(data_out_valid), 64'd1);
            check($sformatf("fwft drain dout %0d", i), 64'(data_out), 64'(i));
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, '0);
        check("fwft drained dov", 64'(data_out_valid), 64'd0);
        check("fwft drained fill", 64'(fill_level), 64'd0);

        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 48'(i));
            tick();
        end
        tick();
        set_in(1'b1, 1'b1, 1'b1, 48'h55);
        tick();
        set_in(1'b0, 1'b0, 1'b0, '0);
        check("fwft flush dov", 64'(data_out_valid), 64'd0);
        check("fwft flush fill", 64'(fill_level), 64'd0);
        check("fwft flush ovf", 64'(overflow), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0);
        model_reset();
`ifdef ADC_STREAM_FIFO_FWFT_EN
        run_fwft();
`else
        run_std();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
